// File: rtl/operational_unit.sv
// Datapath of a microprogrammed processor: two operand registers, a loop counter,
// carry/overflow flags and a result latch, all driven by an 8-bit microcommand word.
module operational_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] C,
  input  logic [7:0] D,
  output logic [7:0] U,
  output logic [7:0] R,
  output logic       valid,
  output logic [3:0] cnt
);

  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       cf_reg, cf_next;
  logic       ovf_reg, ovf_next;
  logic [7:0] r_reg, r_next;
  logic       valid_reg, valid_next;

  logic [8:0] sum;
  logic       add_ovf;

  assign sum     = {1'b0, a_reg} + {1'b0, b_reg};
  // Signed overflow: operands agree in sign but the 8-bit result does not.
  assign add_ovf = (a_reg[7] == b_reg[7]) && (sum[7] != a_reg[7]);

  always_comb begin
    a_next     = a_reg;
    b_next     = b_reg;
    cnt_next   = cnt_reg;
    cf_next    = cf_reg;
    ovf_next   = ovf_reg;
    r_next     = r_reg;
    valid_next = 1'b0;

    if (en) begin
      if (C[0]) begin
        a_next   = D;
        cf_next  = 1'b0;
        ovf_next = 1'b0;
      end else if (C[2]) begin
        a_next   = sum[7:0];
        cf_next  = sum[8];
        ovf_next = ovf_reg | add_ovf;
      end else if (C[4]) begin
        a_next = {a_reg[6:0], 1'b0};
      end

      if (C[1]) begin
        b_next = D;
      end else if (C[3]) begin
        b_next = {1'b0, b_reg[7:1]};
      end

      if (C[5]) begin
        cnt_next = D[3:0];
      end else if (C[6] && (cnt_reg != 4'd0)) begin
        cnt_next = cnt_reg - 4'd1;
      end

      if (C[7]) begin
        r_next     = a_reg;
        valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      cnt_reg   <= 4'h0;
      cf_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      r_reg     <= 8'h00;
      valid_reg <= 1'b0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      cnt_reg   <= cnt_next;
      cf_reg    <= cf_next;
      ovf_reg   <= ovf_next;
      r_reg     <= r_next;
      valid_reg <= valid_next;
    end
  end

  // Condition word depends on registered state only.
  assign U[0] = (a_reg == 8'h00);
  assign U[1] = (b_reg == 8'h00);
  assign U[2] = cf_reg;
  assign U[3] = (cnt_reg == 4'h0);
  assign U[4] = a_reg[7];
  assign U[5] = b_reg[0];
  assign U[6] = (a_reg >= b_reg);
  assign U[7] = ovf_reg;

  assign R     = r_reg;
  assign valid = valid_reg;
  assign cnt   = cnt_reg;

endmodule

// File: tb/tb_operational_unit.sv
// Randomized and directed bench for operational_unit with a queue-based scoreboard
// fed by an arithmetic reference model.
module tb_operational_unit;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] C;
  logic [7:0] D;
  logic [7:0] U;
  logic [7:0] R;
  logic       valid;
  logic [3:0] cnt;

  operational_unit dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .C     (C),
    .D     (D),
    .U     (U),
    .R     (R),
    .valid (valid),
    .cnt   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] u;
    logic [3:0] cnt;
    logic       valid;
    logic [7:0] r;
  } exp_t;

  exp_t       state_q[$];
  logic [7:0] r_q[$];

  int passed = 0;
  int total  = 0;

  // Reference model state kept as plain integers.
  int m_a = 0, m_b = 0, m_cnt = 0, m_cf = 0, m_ovf = 0, m_r = 0, m_valid = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [7:0] model_u();
    logic [7:0] u;
    u[0] = (m_a == 0);
    u[1] = (m_b == 0);
    u[2] = (m_cf != 0);
    u[3] = (m_cnt == 0);
    u[4] = (m_a >= 128);
    u[5] = (m_b % 2 == 1);
    u[6] = (m_a >= m_b);
    u[7] = (m_ovf != 0);
    return u;
  endfunction

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic model_update(input logic r_i, input logic e_i, input logic [7:0] c_i, input logic [7:0] d_i);
    int na, nb, nc, ncf, novf, s;
    if (r_i) begin
      m_a = 0; m_b = 0; m_cnt = 0; m_cf = 0; m_ovf = 0; m_r = 0; m_valid = 0;
      return;
    end
    if (!e_i) begin
      m_valid = 0;
      return;
    end
    na = m_a; nb = m_b; nc = m_cnt; ncf = m_cf; novf = m_ovf;
    if (c_i[0]) begin
      na = int'(d_i); ncf = 0; novf = 0;
    end else if (c_i[2]) begin
      na   = (m_a + m_b) % 256;
      ncf  = (m_a + m_b > 255) ? 1 : 0;
      s    = to_signed8(m_a) + to_signed8(m_b);
      if (s > 127 || s < -128) novf = 1;
    end else if (c_i[4]) begin
      na = (m_a * 2) % 256;
    end
    if (c_i[1]) nb = int'(d_i);
    else if (c_i[3]) nb = m_b / 2;
    if (c_i[5]) nc = int'(d_i) % 16;
    else if (c_i[6]) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
    m_valid = c_i[7] ? 1 : 0;
    if (c_i[7]) begin
      m_r = m_a;
      r_q.push_back(8'(m_a));
    end
    m_a = na; m_b = nb; m_cnt = nc; m_cf = ncf; m_ovf = novf;
  endtask

  task automatic step(input logic r_i, input logic e_i, input logic [7:0] c_i, input logic [7:0] d_i);
    exp_t e;
    @(negedge clk);
    rst = r_i; en = e_i; C = c_i; D = d_i;
    @(posedge clk);
    #1;
    model_update(r_i, e_i, c_i, d_i);
    e.u     = model_u();
    e.cnt   = 4'(m_cnt);
    e.valid = (m_valid != 0);
    e.r     = 8'(m_r);
    state_q.push_back(e);
  endtask

  // Monitor: compares the per-cycle state and pops a result whenever valid is seen.
  initial begin
    exp_t e;
    logic [7:0] er;
    forever begin
      @(negedge clk);
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        check("u", 16'(U), 16'(e.u));
        check("cnt", 16'(cnt), 16'(e.cnt));
        check("valid", 16'(valid), 16'(e.valid));
        check("r_reg", 16'(R), 16'(e.r));
      end
      if (valid === 1'b1) begin
        if (r_q.size() == 0) begin
          check("unexpected_valid", 16'(valid), 16'h0);
        end else begin
          er = r_q.pop_front();
          check("r_result", 16'(R), 16'(er));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; C = 8'h00; D = 8'h00;

    step(1'b1, 1'b1, 8'hFF, 8'hAA);
    check("reset_r", 16'(R), 16'h00);
    check("reset_valid", 16'(valid), 16'h0);
    check("reset_cnt", 16'(cnt), 16'h0);
    check("reset_u", 16'(U), 16'h4B);

    step(1'b0, 1'b1, 8'h03, 8'h0F);
    step(1'b0, 1'b1, 8'h04, 8'h0F);
    check("add_basic_u", 16'(U), 16'h68);
    step(1'b0, 1'b1, 8'h80, 8'h00);
    check("add_basic_r", 16'(R), 16'h1E);
    check("add_basic_valid", 16'(valid), 16'h1);

    step(1'b0, 1'b1, 8'h01, 8'hF0);
    step(1'b0, 1'b1, 8'h02, 8'h20);
    step(1'b0, 1'b1, 8'h04, 8'h00);
    check("carry_u", 16'(U), 16'h0C);
    step(1'b0, 1'b1, 8'h01, 8'h70);
    step(1'b0, 1'b1, 8'h02, 8'h10);
    step(1'b0, 1'b1, 8'h04, 8'h00);
    check("ovf_u", 16'(U), 16'hD8);

    step(1'b0, 1'b1, 8'h05, 8'h22);
    check("load_beats_add_u", 16'(U), 16'h48);
    step(1'b0, 1'b1, 8'h60, 8'h09);
    check("load_beats_dec_cnt", 16'(cnt), 16'h9);

    step(1'b0, 1'b1, 8'h20, 8'h03);
    check("cnt_load", 16'(cnt), 16'h3);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h40, 8'h00);
      check("cnt_dec", 16'(cnt), 16'((i < 3) ? 2 - i : 0));
      check("cnt_zero_flag", 16'(U[3]), 16'((i >= 2) ? 1 : 0));
    end

    step(1'b0, 1'b1, 8'h01, 8'h55);
    step(1'b0, 1'b1, 8'h84, 8'h00);
    check("capture_r", 16'(R), 16'h55);
    check("capture_valid", 16'(valid), 16'h1);
    step(1'b0, 1'b0, 8'hFF, 8'h33);
    check("hold_valid", 16'(valid), 16'h0);
    check("hold_r", 16'(R), 16'h55);
    check("hold_u", 16'(U), 16'h48);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    @(negedge clk);
    check("results_drained", 16'(r_q.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
